mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand and HI/LO width; legal values are 8, 16, 32 and 64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, SHALL set the iteration counter width; it is derived, not overridden.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request a new operation; sampled only in IDLE.
REQ-006 op  input  2  SHALL encode the operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 operand_a  input  WIDTH  SHALL carry the multiplicand or dividend (rs).
REQ-008 operand_b  input  WIDTH  SHALL carry the multiplier or divisor (rt).
REQ-009 flush  input  1  SHALL abort an in-flight operation (pipeline flush).
REQ-010 hi_we / lo_we  input  1 each  SHALL request an mthi / mtlo write of wdata.
REQ-011 wdata  input  WIDTH  SHALL carry the mthi/mtlo data.
REQ-012 hi / lo  output  WIDTH each  SHALL present the architectural HI/LO registers (mfhi/mflo).
REQ-013 busy  output  1  SHALL stall the pipeline while high.
REQ-014 done  output  1  SHALL be a one-cycle pulse marking HI/LO update.
REQ-015 div_by_zero  output  1  SHALL pulse together with done for DIV/DIVU when operand_b==0.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and FIX; reset enters IDLE.
REQ-017 In IDLE, start=1 SHALL latch op and operands, load the counter with WIDTH, and enter RUN at the next edge.
REQ-018 For signed ops, the operand magnitudes SHALL be latched at start, and the result sign SHALL be recorded.
REQ-019 RUN SHALL perform one radix-2 step per cycle (shift-add multiply, restoring divide) and SHALL last exactly WIDTH cycles.
REQ-020 FIX SHALL apply the sign correction, write HI/LO, assert done for that one cycle, and return to IDLE.
REQ-021 busy SHALL be high in RUN and FIX; latency SHALL be start edge to done = WIDTH+2 cycles (34 at WIDTH=32).
REQ-022 MULT/MULTU SHALL write the full 2*WIDTH product: {HI,LO}.
REQ-023 DIV/DIVU SHALL write LO=quotient and HI=remainder.
REQ-024 Signed quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-025 Divide by zero SHALL produce LO=all ones and HI=operand_a (raw), with div_by_zero=1; the full latency SHALL still be observed.
REQ-026 DIV of most-negative by -1 SHALL produce LO=most-negative and HI=0 with no flag.
REQ-027 start while busy SHALL be ignored.
REQ-028 hi_we/lo_we while busy SHALL be ignored.
REQ-029 In IDLE, hi_we/lo_we SHALL write at the next edge; if start is also asserted, start SHALL win and the writes SHALL be dropped.
REQ-030 flush in RUN or FIX SHALL return to IDLE at the next edge with no done and HI/LO unchanged; flush has priority over FIX completion.
REQ-031 flush in IDLE SHALL have no effect; flush and start together in IDLE SHALL not start an operation.

Reset
REQ-032 Asserting reset SHALL immediately force hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE and counter=0, including mid-operation.
REQ-033 Release of reset SHALL need no extra cycles: start is accepted on the first edge after release.

Structure
REQ-034 Package mdu_pkg SHALL hold the op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state enum for the Control unit and the processor top.
REQ-035 One sub-module, mdu_negate (parametrised two's-complement conditional negate), SHALL be used for operand magnitude and result fixup.
REQ-036 The block SHALL use no memories and no multiplier primitives, and all flops SHALL be on clk.

Verification (WIDTH=32)
REQ-037 MULT with a=0xFFFFFFFD, b=7 -> done exactly 34 cycles after start, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-038 MULTU with a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; busy high for 34 cycles.
REQ-039 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-040 DIV 0x1234/0 -> LO=0xFFFFFFFF, HI=0x1234, div_by_zero=1 with done; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-041 With HI/LO preloaded by mthi 0xA5, mtlo 0x5A: start MULT, then start plus hi_we at RUN cycle 5 -> both ignored; flush at RUN cycle 10 -> no done, HI=0xA5, LO=0x5A, busy low next cycle.
REQ-042 Reset pulse at RUN cycle 20 -> HI=LO=0 and busy=0 asynchronously; a new start on the first edge after release completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encoding,
// control FSM state type and small decode helpers.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    // Signed variants take operand magnitudes and fix the result sign at the end.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate: result = neg ? -value : value.
// Used both to take operand magnitudes and to apply the final sign fixup.
module mdu_negate #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] value,
    output logic [W-1:0] result
);

    assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per cycle: shift-add multiply, restoring divide on
// unsigned magnitudes, with the sign applied in a single FIX cycle.
//
// Handshake: start is a request qualified only in IDLE. busy rises
// combinationally in the cycle a start is accepted and stays high through
// RUN and FIX, so the issuing pipeline stalls from the issue cycle onward.
// done (with div_by_zero) is a one-cycle pulse in the cycle the new HI/LO
// values first become visible; it is never raised for a flushed operation.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output state_t           state
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;

    logic               load_en, step_en, commit;

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH-1:0]   mag_b_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   qr_q;
    logic               neg_res_q, neg_rem_q, b_zero_q;

    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dbz_q;

    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [WIDTH-1:0]   acc_step, qr_step;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic [WIDTH-1:0]   hi_res, lo_res;

    // Operand signs only matter for the signed variants.
    assign sgn_a = op_is_signed(op) & operand_a[WIDTH-1];
    assign sgn_b = op_is_signed(op) & operand_b[WIDTH-1];

    mdu_negate #(.W(WIDTH)) u_mag_a (
        .neg    (sgn_a),
        .value  (operand_a),
        .result (mag_a)
    );

    mdu_negate #(.W(WIDTH)) u_mag_b (
        .neg    (sgn_b),
        .value  (operand_b),
        .result (mag_b)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: flush always wins over progress or completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start && !flush) state_d = ST_RUN;
            ST_RUN: begin
                if (flush)                    state_d = ST_IDLE;
                else if (cnt_q == CNT_W'(1))  state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs. The reset term keeps busy low while reset is held even if
    // start happens to be high.
    always_comb begin
        load_en = 1'b0;
        step_en = 1'b0;
        commit  = 1'b0;
        busy    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_en = start & ~flush & reset;
                busy    = load_en;
            end
            ST_RUN: begin
                step_en = ~flush;
                busy    = 1'b1;
            end
            ST_FIX: begin
                commit  = ~flush;
                busy    = 1'b1;
            end
            default: ;
        endcase
    end

    // One radix-2 step. Multiply: {acc,qr} shifts right, adding the
    // multiplicand into acc when the current multiplier bit is set.
    // Divide: {acc,qr} shifts left, subtracting the divisor when it fits.
    // The remainder stays below the divisor, so WIDTH+1 bits hold the trial.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (qr_q[0] ? {1'b0, mag_b_q} : '0);
        div_shift = {acc_q, qr_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, mag_b_q};
        acc_step  = acc_q;
        qr_step   = qr_q;
        if (op_is_div(op_q)) begin
            if (!div_trial[WIDTH]) begin
                acc_step = div_trial[WIDTH-1:0];
                qr_step  = {qr_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = div_shift[WIDTH-1:0];
                qr_step  = {qr_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = mul_sum[WIDTH:1];
            qr_step  = {mul_sum[0], qr_q[WIDTH-1:1]};
        end
    end

    // Operation datapath: latch operands on accept, iterate in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= OP_MULT;
            a_raw_q   <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            qr_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            cnt_q     <= '0;
        end else if (load_en) begin
            op_q      <= op;
            a_raw_q   <= operand_a;
            mag_b_q   <= mag_b;
            acc_q     <= '0;
            qr_q      <= mag_a;
            neg_res_q <= sgn_a ^ sgn_b;
            neg_rem_q <= sgn_a;
            b_zero_q  <= (operand_b == '0);
            cnt_q     <= CNT_W'(WIDTH);
        end else if (step_en) begin
            acc_q     <= acc_step;
            qr_q      <= qr_step;
            cnt_q     <= cnt_q - CNT_W'(1);
        end else if (flush && state_q != ST_IDLE) begin
            cnt_q     <= '0;
        end
    end

    mdu_negate #(.W(2*WIDTH)) u_fix_prod (
        .neg    (neg_res_q),
        .value  ({acc_q, qr_q}),
        .result (prod_fix)
    );

    mdu_negate #(.W(WIDTH)) u_fix_quot (
        .neg    (neg_res_q),
        .value  (qr_q),
        .result (quot_fix)
    );

    mdu_negate #(.W(WIDTH)) u_fix_rem (
        .neg    (neg_rem_q),
        .value  (acc_q),
        .result (rem_fix)
    );

    // Final HI/LO values. Most-negative / -1 needs no special case: the
    // magnitude quotient 2^(WIDTH-1) negates back to itself with remainder 0.
    always_comb begin
        hi_res = prod_fix[2*WIDTH-1:WIDTH];
        lo_res = prod_fix[WIDTH-1:0];
        if (op_is_div(op_q)) begin
            if (b_zero_q) begin
                hi_res = a_raw_q;
                lo_res = '1;
            end else begin
                hi_res = rem_fix;
                lo_res = quot_fix;
            end
        end
    end

    // Architectural HI/LO plus completion pulses. mthi/mtlo only land in
    // IDLE when no start is presented in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= commit;
            dbz_q  <= commit & op_is_div(op_q) & b_zero_q;
            if (commit) begin
                hi_q <= hi_res;
                lo_q <= lo_res;
            end else if (state_q == ST_IDLE && !start) begin
                if (hi_we) hi_q <= wdata;
                if (lo_we) lo_q <= wdata;
            end
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 2;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op = OP_MULT;
    logic [WIDTH-1:0] operand_a = '0;
    logic [WIDTH-1:0] operand_b = '0;
    logic             flush = 1'b0;
    logic             hi_we = 1'b0;
    logic             lo_we = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic [WIDTH-1:0] hi, lo;
    logic             busy, done, div_by_zero;
    state_t           state;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .flush       (flush),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .state       (state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [2*WIDTH:0] exp_q[$];     // {div_by_zero, hi, lo}
    logic [WIDTH-1:0] model_hi = '0;
    logic [WIDTH-1:0] model_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model built on the simulator's own arithmetic.
    function automatic logic [2*WIDTH:0] model(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [63:0] p;
        longint      sa, sb;
        logic [WIDTH-1:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MULT:  begin p = 64'(sa * sb); return {1'b0, p}; end
            OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
            default: begin
                if (b == '0) return {1'b1, a, 32'hFFFF_FFFF};
                if (o == OP_DIV) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
                    q = 32'(sa / sb);
                    r = 32'(sa % sb);
                end else begin
                    q = a / b;
                    r = a % b;
                end
                return {1'b0, r, q};
            end
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; presents start for one cycle and
    // follows the operation to its done pulse.
    task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH:0] e;
        int cycles, busy_cycles;
        bit seen;
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        exp_q.push_back(model(o, a, b));
        #1;
        busy_cycles = busy ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        cycles = 1;
        seen = 1'b0;
        check("hold_hi", 64'(hi), 64'(model_hi));
        check("hold_lo", 64'(lo), 64'(model_lo));
        while (!seen && cycles < 100) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) busy_cycles++;
                @(negedge clk);
                cycles++;
            end
        end
        if (!seen) begin
            check("done_timeout", 64'(0), 64'(1));
            void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            check("queue_empty", 64'(0), 64'(1));
        end else begin
            e = exp_q.pop_front();
            check("hi", 64'(hi), 64'(e[63:32]));
            check("lo", 64'(lo), 64'(e[31:0]));
            check("div_by_zero", 64'(div_by_zero), 64'(e[64]));
            check("latency", 64'(cycles), 64'(LAT));
            check("busy_cycles", 64'(busy_cycles), 64'(LAT));
            check("busy_at_done", 64'(busy), 64'(0));
            model_hi = e[63:32];
            model_lo = e[31:0];
            @(negedge clk);
            check("done_pulse", 64'(done), 64'(0));
            check("dbz_pulse", 64'(div_by_zero), 64'(0));
        end
    endtask

    task automatic write_reg(input bit to_hi, input logic [WIDTH-1:0] d);
        hi_we = to_hi;
        lo_we = !to_hi;
        wdata = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (to_hi) model_hi = d; else model_lo = d;
        check(to_hi ? "mthi" : "mtlo", to_hi ? 64'(hi) : 64'(lo), 64'(d));
    endtask

    // Starts an operation that will never complete (flush/reset follow);
    // leaves the bench at the falling edge of RUN cycle 1.
    task automatic start_untracked(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic watch_no_done(input string tag, input int n);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check(tag, 64'(pulses), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #12;
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_dbz", 64'(div_by_zero), 64'(0));
        check("rst_state", 64'(state), 64'(ST_IDLE));
        @(negedge clk);
        reset = 1'b1;

        // Directed cases; first start lands on the first edge after release.
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        run_op(OP_DIVU,  32'd7,         32'd2);
        run_op(OP_DIV,   32'h0000_1234, 32'd0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op(OP_DIVU,  32'hDEAD_BEEF, 32'd0);
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE);

        // start together with mthi/mtlo in IDLE: the writes are dropped.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        run_op(OP_MULTU, 32'd2, 32'd3);

        // Preload, then start/mthi ignored while busy, then flush in RUN.
        write_reg(1'b1, 32'h0000_00A5);
        write_reg(1'b0, 32'h0000_005A);
        start_untracked(OP_MULT, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd3;
        start = 1'b1; hi_we = 1'b1; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("busy_mthi_hi", 64'(hi), 64'(32'hA5));
        check("run_state", 64'(state), 64'(ST_RUN));
        repeat (4) @(negedge clk);
        check("run_busy", 64'(busy), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_state", 64'(state), 64'(ST_IDLE));
        check("flush_hi", 64'(hi), 64'(32'hA5));
        check("flush_lo", 64'(lo), 64'(32'h5A));
        watch_no_done("flush_run_done", 40);

        // Flush in the FIX cycle beats completion.
        start_untracked(OP_MULTU, 32'd2, 32'd2);
        repeat (WIDTH) @(negedge clk);
        check("fix_state", 64'(state), 64'(ST_FIX));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fix_flush_done", 64'(done), 64'(0));
        check("fix_flush_state", 64'(state), 64'(ST_IDLE));
        check("fix_flush_hi", 64'(hi), 64'(32'hA5));
        check("fix_flush_lo", 64'(lo), 64'(32'h5A));
        watch_no_done("flush_fix_done", 5);

        // flush together with start in IDLE starts nothing.
        op = OP_MULT; operand_a = 32'd9; operand_b = 32'd9;
        start = 1'b1; flush = 1'b1;
        #1;
        check("idle_flush_busy", 64'(busy), 64'(0));
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idle_flush_state", 64'(state), 64'(ST_IDLE));
        check("idle_flush_busy2", 64'(busy), 64'(0));

        // Asynchronous reset in the middle of RUN, then immediate restart.
        start_untracked(OP_MULT, 32'h0001_2345, 32'h0000_0777);
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_hi", 64'(hi), 64'(0));
        check("mid_rst_lo", 64'(lo), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_state", 64'(state), 64'(ST_IDLE));
        model_hi = '0;
        model_lo = '0;
        #1;
        reset = 1'b1;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);

        // Random operations with corner-biased operands.
        for (int i = 0; i < 24; i++) begin
            logic [1:0]       ro;
            logic [WIDTH-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = pick_operand();
            rb = pick_operand();
            run_op(ro, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop in case a wait is never satisfied.
    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
